// File: rtl/ads1292_filter_pkg.sv
// ads1292_filter_pkg
// Shared widths, default parameter values and types for the ADS1292
// filter test build.
//   SAMPLE_W  : width of an ADS1292-format sample (24-bit signed)
//   OUT_W     : width of the filtered output word (32-bit signed)
//   DEF_*     : default values for the top-level parameters
//   sample_t  : signed 24-bit sample
//   out_t     : signed 32-bit output word
//   phase_t   : test square-wave phase (encoded so that reset value 0 = high)
package ads1292_filter_pkg;

  localparam int SAMPLE_W = 24;
  localparam int OUT_W    = 32;

  localparam int DEF_SAMPLE_DIV = 50;
  localparam int DEF_TAPS_LOG2  = 3;
  localparam int DEF_SQ_HALF    = 16;
  localparam int DEF_AMP        = 100000;
  localparam int DEF_DC         = 4096;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [OUT_W-1:0]    out_t;

  typedef enum logic {
    PH_HIGH = 1'b0,
    PH_LOW  = 1'b1
  } phase_t;

endpackage

// File: rtl/ads1292_filter_if.sv
// ads1292_filter_if
// Sample bus between the waveform generator and the moving-average FIR.
//   sample_valid : one-cycle strobe, a new sample is present
//   sample       : signed 24-bit sample
//   avg          : FIR average that the current strobe produces
// Modports: master drives samples and reads the average, slave (the filter)
// consumes samples and drives the average.
interface ads1292_filter_if;
  import ads1292_filter_pkg::*;

  logic    sample_valid;
  sample_t sample;
  out_t    avg;

  modport master (output sample_valid, output sample, input avg);
  modport slave  (input sample_valid, input sample, output avg);

endinterface

// File: rtl/moving_average_fir.sv
// moving_average_fir
// Moving-average low-pass over 2^TAPS_LOG2 samples, kept as a running sum.
// Ports:
//   clk  : system clock
//   rstn : synchronous reset, active-high (clears delay line and sum)
//   bus  : slave side of the sample bus; on sample_valid the sample is
//          shifted in and the sum updated. bus.avg is the average the
//          current sample produces (acc_new >>> TAPS_LOG2, sign-extended),
//          so the owner can register it on the same edge as the sum.
module moving_average_fir
  import ads1292_filter_pkg::*;
#(
  parameter int TAPS_LOG2 = DEF_TAPS_LOG2
) (
  input  logic               clk,
  input  logic               rstn,
  ads1292_filter_if.slave    bus
);

  localparam int TAPS  = 1 << TAPS_LOG2;
  localparam int ACC_W = SAMPLE_W + TAPS_LOG2;

  sample_t                  dl [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  acc_shr;

  // Sum of the window including the incoming sample; the oldest tap drops out.
  always_comb begin
    acc_nxt = acc + ACC_W'(bus.sample) - ACC_W'(dl[TAPS-1]);
    acc_shr = acc_nxt >>> TAPS_LOG2;
    bus.avg = OUT_W'(acc_shr);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      acc <= '0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        dl[i] <= '0;
      end
    end else if (bus.sample_valid) begin
      acc   <= acc_nxt;
      dl[0] <= bus.sample;
      for (int unsigned i = 1; i < TAPS; i++) begin
        dl[i] <= dl[i-1];
      end
    end
  end

endmodule

// File: rtl/ads1292_filter_test_top.sv
// ads1292_filter_test_top
// Self-contained filter test harness: divides clk down to a sample tick,
// generates a DC-offset square wave in ADS1292 format and filters it with a
// moving-average FIR. The filtered value is registered onto `out`, updating
// one clk after each tick and holding in between.
// Ports:
//   clk  : system clock
//   rstn : synchronous reset, active-high (1 = reset)
//   out  : filtered sample, signed 32-bit
// Build option: define DC_REMOVE_EN to add a first-order DC blocker after
// the FIR: h[n] = m[n] - m[n-1] + h[n-1] - (h[n-1] >>> 6).
module ads1292_filter_test_top
  import ads1292_filter_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int TAPS_LOG2  = DEF_TAPS_LOG2,
  parameter int SQ_HALF    = DEF_SQ_HALF,
  parameter int AMP        = DEF_AMP,
  parameter int DC         = DEF_DC
) (
  input  logic                    clk,
  input  logic                    rstn,
  output logic signed [OUT_W-1:0] out
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int SC_W  = (SQ_HALF > 1) ? $clog2(SQ_HALF) : 1;

  localparam sample_t HI_LVL = sample_t'(DC + AMP);
  localparam sample_t LO_LVL = sample_t'(DC - AMP);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [SC_W-1:0]  scnt;
  logic             half_done;
  phase_t           phase;
  phase_t           phase_nxt;

  ads1292_filter_if fir_bus ();

  // Sample-rate divider
  assign tick = (cnt == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Samples within the current half-period
  assign half_done = (scnt == SC_W'(SQ_HALF - 1));

  always_ff @(posedge clk) begin
    if (rstn) begin
      scnt <= '0;
    end else if (tick) begin
      scnt <= half_done ? '0 : scnt + SC_W'(1);
    end
  end

  // Square-wave phase
  always_ff @(posedge clk) begin
    if (rstn) begin
      phase <= PH_HIGH;
    end else begin
      phase <= phase_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    if (tick && half_done) begin
      case (phase)
        PH_HIGH: phase_nxt = PH_LOW;
        PH_LOW:  phase_nxt = PH_HIGH;
        default: phase_nxt = PH_HIGH;
      endcase
    end
  end

  always_comb begin
    fir_bus.sample_valid = tick;
    fir_bus.sample       = (phase == PH_HIGH) ? HI_LVL : LO_LVL;
  end

  moving_average_fir #(
    .TAPS_LOG2 (TAPS_LOG2)
  ) u_fir (
    .clk  (clk),
    .rstn (rstn),
    .bus  (fir_bus)
  );

`ifdef DC_REMOVE_EN
  // `out` doubles as the blocker state h[n-1]; m_prev holds m[n-1].
  out_t m_prev;
  out_t h_nxt;

  always_comb begin
    h_nxt = fir_bus.avg - m_prev + out - (out >>> 6);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      m_prev <= '0;
      out    <= '0;
    end else if (tick) begin
      m_prev <= fir_bus.avg;
      out    <= h_nxt;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rstn) begin
      out <= '0;
    end else if (tick) begin
      out <= fir_bus.avg;
    end
  end
`endif

endmodule

// File: tb/tb_ads1292_filter_test_top.sv
// tb_ads1292_filter_test_top
// Scoreboard bench for ads1292_filter_test_top (default build). The stimulus
// process drives reset and queues (cycle, expected out) pairs; the monitor
// compares `out` on the falling edge of each queued cycle.
module tb_ads1292_filter_test_top;

  localparam int DIV = 50;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] out_w;

  ads1292_filter_if mon ();

  ads1292_filter_test_top #(
    .SAMPLE_DIV (DIV),
    .TAPS_LOG2  (3),
    .SQ_HALF    (16),
    .AMP        (100000),
    .DC         (4096)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .out  (out_w)
  );

  assign mon.avg          = out_w;
  assign mon.sample_valid = 1'b0;
  assign mon.sample       = '0;

  always #10 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input string name, input int c, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.cyc  = c;
    e.val  = v;
    q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin : monitor_p
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_tests++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: check cycle %0d passed unseen (now %0d)", e.name, e.cyc, cyc);
      end else if (mon.avg !== e.val) begin
        n_fail++;
        $display("FAIL %s: out=%0d (0x%08h) expected %0d (0x%08h)",
                 e.name, $signed(mon.avg), mon.avg, $signed(e.val), e.val);
      end
    end
  end

  task automatic drain(input int limit);
    while (q.size() > 0 && cyc < limit) @(negedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks never reached by cycle %0d", q.size(), limit);
      q.delete();
    end
  endtask

  initial begin
    int r0;
    int r1;

    // Power-on reset, 5 cycles
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    r0 = cyc;

    expect_at("reset_state", r0 + 1, 32'd0);
    expect_at("pre_tick",    r0 + DIV - 1, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      expect_at($sformatf("ramp_s%0d", k), r0 + DIV * k, 32'(13012 * k));
    end
    expect_at("s10",      r0 + DIV * 10, 32'd104096);
    expect_at("s10_hold", r0 + DIV * 10 + 5, 32'd104096);

    // One-cycle reset in the middle of sample 10
    while (cyc < r0 + DIV * 10 + 5) @(negedge clk);
    rstn = 1'b1;
    expect_at("mid_reset", r0 + DIV * 10 + 6, 32'd0);
    @(negedge clk);
    rstn = 1'b0;
    r1 = cyc;

    expect_at("rs_pre_tick", r1 + DIV - 1, 32'd0);
    expect_at("rs_s1",       r1 + DIV * 1,  32'd13012);
    expect_at("rs_s2",       r1 + DIV * 2,  32'd26024);
    expect_at("rs_s8",       r1 + DIV * 8,  32'd104096);
    expect_at("rs_s16",      r1 + DIV * 16, 32'd104096);
    expect_at("rs_s17",      r1 + DIV * 17, 32'd79096);
    expect_at("rs_s20",      r1 + DIV * 20, 32'd4096);
    expect_at("rs_s24_sext", r1 + DIV * 24, 32'hFFFE8960);
    expect_at("rs_s32",      r1 + DIV * 32, 32'hFFFE8960);
    expect_at("rs_s33",      r1 + DIV * 33, 32'hFFFEEB08);
    expect_at("rs_s39_hold", r1 + DIV * 40 - 1, 32'd79096);
    expect_at("rs_s40",      r1 + DIV * 40, 32'd104096);

    drain(r1 + DIV * 42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
